// File: rtl/sha2_round_engine.sv
// sha2_round_engine
//   Iterative SHA-2 compression engine. Holds the working variables a..h and
//   applies one compression round for every accepted (W_t + K_t) word. WORD_W
//   selects SHA-256 (32) or SHA-512 (64) arithmetic and rotation amounts.
//
// Parameters
//   WORD_W    word width, 32 or 64
//   ROUNDS    rounds per block, 1..255 (64 for SHA-256, 80 for SHA-512)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   load       start pulse, sampled only in IDLE
//   h_in       chaining value, a in the top word down to h in the bottom word
//   wk_valid   wk_in carries a valid round word
//   wk_in      (W_t + K_t) mod 2^WORD_W for the current round
//   wk_ready   engine accepts wk_in (high exactly while in RUN)
//   busy       engine not IDLE
//   done       one-cycle pulse, h_out valid while high
//   h_out      block result, same packing as h_in, held until next completion
//   round_cnt  rounds completed in the current block
//
// Configuration macro
//   SHA2_ROUND_FEEDFORWARD_EN  when defined, h_out = a..h + captured chaining
//                              value (new chaining value); otherwise h_out is
//                              the raw a..h and the caller adds the chain.
module sha2_round_engine #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [8*WORD_W-1:0]   h_in,
    input  logic                  wk_valid,
    input  logic [WORD_W-1:0]     wk_in,
    output logic                  wk_ready,
    output logic                  busy,
    output logic                  done,
    output logic [8*WORD_W-1:0]   h_out,
    output logic [7:0]            round_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int S0_R0 = (WORD_W == 64) ? 28 : 2;
    localparam int S0_R1 = (WORD_W == 64) ? 34 : 13;
    localparam int S0_R2 = (WORD_W == 64) ? 39 : 22;
    localparam int S1_R0 = (WORD_W == 64) ? 14 : 6;
    localparam int S1_R1 = (WORD_W == 64) ? 18 : 11;
    localparam int S1_R2 = (WORD_W == 64) ? 41 : 25;

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    state_e                  state_q, state_d;
    // Word 7 is a, word 0 is h, so h_in maps onto the array without reordering.
    logic [7:0][WORD_W-1:0]  work_q, work_d;
    logic [7:0][WORD_W-1:0]  h_out_q, h_out_d;
    logic [7:0][WORD_W-1:0]  result;
    logic [7:0]              round_cnt_q, round_cnt_d;
    logic                    done_q, done_d;

    logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
    logic [WORD_W-1:0] sig0, sig1, ch, maj, t1, t2;
    logic              xfer;

    assign {a, b, c, d, e, f, g, h} = work_q;

    // Handshake: a round word is consumed on any rising edge where
    // wk_valid && wk_ready. wk_ready depends on state only, never on wk_valid,
    // so the producer may hold wk_valid high or drop it for any number of
    // cycles; nothing moves while no transfer happens.
    assign wk_ready = (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign xfer     = wk_valid && wk_ready;

    always_comb begin
        sig0 = rotr(a, S0_R0) ^ rotr(a, S0_R1) ^ rotr(a, S0_R2);
        sig1 = rotr(e, S1_R0) ^ rotr(e, S1_R1) ^ rotr(e, S1_R2);
        ch   = (e & f) ^ (~e & g);
        maj  = (a & b) ^ (a & c) ^ (b & c);
        t1   = h + sig1 + ch + wk_in;
        t2   = sig0 + maj;
    end

`ifdef SHA2_ROUND_FEEDFORWARD_EN
    logic [7:0][WORD_W-1:0] chain_q, chain_d;

    always_comb begin
        chain_d = chain_q;
        if (state_q == IDLE && load) begin
            chain_d = h_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    // Davies-Meyer feed-forward: word-wise add of the chaining value.
    always_comb begin
        result = '0;
        for (int i = 0; i < 8; i++) begin
            result[i] = work_q[i] + chain_q[i];
        end
    end
`else
    assign result = work_q;
`endif

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        round_cnt_d = round_cnt_q;
        h_out_d     = h_out_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    work_d      = h_in;
                    round_cnt_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    work_d      = {t1 + t2, a, b, c, d + t1, e, f, g};
                    round_cnt_d = round_cnt_q + 8'd1;
                    if (round_cnt_q == LAST_ROUND) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                h_out_d = result;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            h_out_q     <= '0;
            round_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            h_out_q     <= h_out_d;
            round_cnt_q <= round_cnt_d;
            done_q      <= done_d;
        end
    end

    assign h_out     = h_out_q;
    assign done      = done_q;
    assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_sha2_round_engine.sv
// tb_sha2_round_engine
//   Drives three engine instances (SHA-256 with ROUNDS=1, SHA-256 with 64
//   rounds, SHA-512 with 80 rounds) and compares every result against a
//   behavioural SHA-2 compression model. Round constants and IVs are derived
//   here from prime roots; the "abc" message schedule is computed here too.
//   Honors SHA2_ROUND_FEEDFORWARD_EN the same way the design does.
module tb_sha2_round_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   load_v, valid_v;
    logic [511:0] h_in_b;
    logic [63:0]  wk_b;
    logic [2:0]   ready_v, busy_v, done_v;
    logic [255:0] h_out0, h_out1;
    logic [511:0] h_out2;
    logic [7:0]   rc0, rc1, rc2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0]  k64[80];
    logic [63:0]  iv64[8];
    logic [63:0]  wk_tab[80];
    logic [511:0] last_hout[3];
    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    sha2_round_engine #(.WORD_W(32), .ROUNDS(1)) d1 (
        .clk(clk), .rst(rst), .load(load_v[0]), .h_in(h_in_b[255:0]),
        .wk_valid(valid_v[0]), .wk_in(wk_b[31:0]), .wk_ready(ready_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .h_out(h_out0), .round_cnt(rc0)
    );

    sha2_round_engine #(.WORD_W(32), .ROUNDS(64)) d256 (
        .clk(clk), .rst(rst), .load(load_v[1]), .h_in(h_in_b[255:0]),
        .wk_valid(valid_v[1]), .wk_in(wk_b[31:0]), .wk_ready(ready_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .h_out(h_out1), .round_cnt(rc1)
    );

    sha2_round_engine #(.WORD_W(64), .ROUNDS(80)) d512 (
        .clk(clk), .rst(rst), .load(load_v[2]), .h_in(h_in_b),
        .wk_valid(valid_v[2]), .wk_in(wk_b), .wk_ready(ready_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .h_out(h_out2), .round_cnt(rc2)
    );

    task automatic check_eq(input string tag, input logic [511:0] got,
                            input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] wmask(input int w);
        return (w == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        return ((x >> n) | (x << (w - n))) & wmask(w);
    endfunction

    function automatic logic [63:0] bsig0(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 2, w) ^ rotr(x, 13, w) ^ rotr(x, 22, w);
        return rotr(x, 28, w) ^ rotr(x, 34, w) ^ rotr(x, 39, w);
    endfunction

    function automatic logic [63:0] bsig1(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 6, w) ^ rotr(x, 11, w) ^ rotr(x, 25, w);
        return rotr(x, 14, w) ^ rotr(x, 18, w) ^ rotr(x, 41, w);
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
        return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
        return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
    endfunction

    // Word i (0 = a ... 7 = h) of an 8-word packed vector.
    function automatic logic [63:0] get_word(input logic [511:0] vec, input int i, input int w);
        logic [511:0] s;
        s = vec >> (w * (7 - i));
        return s[63:0] & wmask(w);
    endfunction

    function automatic logic [511:0] put_word(input logic [511:0] acc, input logic [63:0] v,
                                              input int i, input int w);
        logic [511:0] t;
        t = {448'b0, v & wmask(w)};
        return acc | (t << (w * (7 - i)));
    endfunction

    function automatic logic [511:0] sha_model(input int w, input int nr, input logic [511:0] iv);
        logic [63:0]  v[8];
        logic [63:0]  m, t1, t2, chv, mj;
        logic [511:0] res;
        m = wmask(w);
        for (int i = 0; i < 8; i++) v[i] = get_word(iv, i, w);
        for (int t = 0; t < nr; t++) begin
            chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
            mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = (v[7] + bsig1(v[4], w) + chv + wk_tab[t]) & m;
            t2  = (bsig0(v[0], w) + mj) & m;
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = (v[4] + t1) & m;
            v[0] = (t1 + t2) & m;
        end
        res = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef SHA2_ROUND_FEEDFORWARD_EN
            res = put_word(res, v[i] + get_word(iv, i, w), i, w);
`else
            res = put_word(res, v[i], i, w);
`endif
        end
        return res;
    endfunction

    // Expected engine output for a known full digest: the digest itself with
    // feed-forward, otherwise digest minus IV word by word.
    function automatic logic [511:0] expect_from_digest(input logic [511:0] dig,
                                                        input logic [511:0] iv, input int w);
`ifdef SHA2_ROUND_FEEDFORWARD_EN
        return dig;
`else
        logic [511:0] res;
        res = '0;
        for (int i = 0; i < 8; i++)
            res = put_word(res, get_word(dig, i, w) - get_word(iv, i, w), i, w);
        return res;
`endif
    endfunction

    function automatic logic [255:0] iroot(input logic [255:0] n, input int k);
        logic [255:0] r, t, p;
        r = '0;
        for (int b = 69; b >= 0; b--) begin
            t = r | (256'd1 << b);
            p = (k == 3) ? t * t * t : t * t;
            if (p <= n) r = t;
        end
        return r;
    endfunction

    task automatic build_abc(input int w, input int nr);
        logic [63:0] ws[80];
        logic [63:0] m, kc;
        m = wmask(w);
        for (int t = 0; t < 16; t++) ws[t] = '0;
        ws[0]  = (w == 32) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
        ws[15] = 64'd24;
        for (int t = 16; t < nr; t++)
            ws[t] = (ssig1(ws[t-2], w) + ws[t-7] + ssig0(ws[t-15], w) + ws[t-16]) & m;
        for (int t = 0; t < nr; t++) begin
            kc = (w == 32) ? (k64[t] >> 32) : k64[t];
            wk_tab[t] = (ws[t] + kc) & m;
        end
    endtask

    // ---------------- DUT access ----------------
    function automatic logic [511:0] get_hout(input int sel);
        case (sel)
            0:       return {256'b0, h_out0};
            1:       return {256'b0, h_out1};
            default: return h_out2;
        endcase
    endfunction

    function automatic logic [7:0] get_rc(input int sel);
        case (sel)
            0:       return rc0;
            1:       return rc1;
            default: return rc2;
        endcase
    endfunction

    function automatic logic [511:0] rand_iv(input int w);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        if (w == 32) r[511:256] = '0;
        return r;
    endfunction

    // Runs one block on instance sel starting at a falling edge (engine idle
    // or in its done cycle) and returns at the falling edge where done shows.
    task automatic run_block(input int sel, input logic [511:0] iv, input int gap_pct,
                             input bit stray, input int abort_at, input logic [511:0] exp_out);
        int nr, idx, budget;
        bit vld;
        logic [511:0] exp_now;
        nr = (sel == 0) ? 1 : (sel == 1) ? 64 : 80;
        idx = 0;
        budget = 0;
        exp_q.push_back(exp_out);
        h_in_b = iv;
        load_v[sel] = 1'b1;
        @(negedge clk);
        load_v[sel] = 1'b0;
        h_in_b = '0;
        check_eq("busy_after_load", busy_v[sel], 1);
        check_eq("done_low_after_load", done_v[sel], 0);
        check_eq("h_out_held", get_hout(sel), last_hout[sel]);
        check_eq("round_cnt_cleared", get_rc(sel), 0);
        while (idx < nr) begin
            if (budget >= 2000) begin
                check_eq("timeout_rounds", idx, nr);
                exp_q.delete();
                return;
            end
            check_eq("ready_in_run", ready_v[sel], 1);
            check_eq("no_done_in_run", done_v[sel], 0);
            vld = ($urandom_range(99) >= gap_pct);
            valid_v[sel] = vld;
            wk_b = vld ? wk_tab[idx] : {$urandom, $urandom};
            if (stray && $urandom_range(3) == 0) begin
                load_v[sel] = 1'b1;
                h_in_b = rand_iv(64);
            end
            @(negedge clk);
            budget++;
            valid_v[sel] = 1'b0;
            load_v[sel] = 1'b0;
            if (vld) idx++;
            check_eq("round_cnt", get_rc(sel), idx);
            if (idx == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_eq("abort_busy", busy_v[sel], 0);
                check_eq("abort_ready", ready_v[sel], 0);
                check_eq("abort_done", done_v[sel], 0);
                check_eq("abort_h_out", get_hout(sel), 0);
                check_eq("abort_round_cnt", get_rc(sel), 0);
                rst = 1'b0;
                @(negedge clk);
                check_eq("abort_no_done", done_v[sel], 0);
                check_eq("abort_idle", busy_v[sel], 0);
                exp_q.delete();
                for (int i = 0; i < 3; i++) last_hout[i] = '0;
                return;
            end
        end
        // FIN cycle: a valid word offered here must not be consumed.
        check_eq("fin_ready_low", ready_v[sel], 0);
        check_eq("fin_busy", busy_v[sel], 1);
        check_eq("fin_done_low", done_v[sel], 0);
        valid_v[sel] = 1'b1;
        wk_b = {$urandom, $urandom};
        @(negedge clk);
        valid_v[sel] = 1'b0;
        exp_now = exp_q.pop_front();
        check_eq("done_pulse", done_v[sel], 1);
        check_eq("idle_at_done", busy_v[sel], 0);
        check_eq("h_out", get_hout(sel), exp_now);
        check_eq("round_cnt_final", get_rc(sel), nr);
        last_hout[sel] = exp_now;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [511:0] iv256, iv512, dig256, dig512, e256, e512, iv, w512, wa;
        logic [255:0] root;
        int p, cnt;
        bit prime;

        rst = 1'b1;
        load_v = '0;
        valid_v = '0;
        h_in_b = '0;
        wk_b = '0;
        for (int i = 0; i < 3; i++) last_hout[i] = '0;

        // Round constants and IVs from the fractional parts of prime roots.
        p = 2;
        cnt = 0;
        while (cnt < 80) begin
            prime = 1'b1;
            for (int q = 2; q * q <= p; q++) if (p % q == 0) prime = 1'b0;
            if (prime) begin
                root = iroot(256'(p) << 192, 3);
                k64[cnt] = root[63:0];
                if (cnt < 8) begin
                    root = iroot(256'(p) << 128, 2);
                    iv64[cnt] = root[63:0];
                end
                cnt++;
            end
            p++;
        end
        iv256 = '0;
        iv512 = '0;
        for (int i = 0; i < 8; i++) begin
            iv256 = put_word(iv256, iv64[i] >> 32, i, 32);
            iv512 = put_word(iv512, iv64[i], i, 64);
        end
        dig256 = {256'b0, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
        dig512 = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
        e256 = expect_from_digest(dig256, iv256, 32);
        e512 = expect_from_digest(dig512, iv512, 64);

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check_eq("reset_busy", busy_v[s], 0);
            check_eq("reset_ready", ready_v[s], 0);
            check_eq("reset_done", done_v[s], 0);
            check_eq("reset_h_out", get_hout(s), 0);
            check_eq("reset_round_cnt", get_rc(s), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single round, zero chain, wk=1: a = e = 1, rest 0.
        wk_tab[0] = 64'd1;
        run_block(0, '0, 0, 1'b0, -1,
                  {256'b0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0});

        // Back-to-back random single-round blocks, load in the done cycle.
        for (int n = 0; n < 4; n++) begin
            iv = rand_iv(32);
            wk_tab[0] = {32'b0, $urandom};
            run_block(0, iv, 0, 1'b0, -1, sha_model(32, 1, iv));
        end
        @(negedge clk);

        // SHA-256 "abc", continuous then with gaps and stray loads.
        build_abc(32, 64);
        run_block(1, iv256, 0, 1'b0, -1, e256);
        run_block(1, iv256, 50, 1'b1, -1, e256);
        @(negedge clk);

        // SHA-256 random blocks.
        for (int n = 0; n < 2; n++) begin
            iv = rand_iv(32);
            for (int t = 0; t < 64; t++) wk_tab[t] = {32'b0, $urandom};
            run_block(1, iv, 30, 1'b1, -1, sha_model(32, 64, iv));
        end
        @(negedge clk);

        // SHA-512 "abc" plus a random block.
        build_abc(64, 80);
        run_block(2, iv512, 0, 1'b0, -1, e512);
        w512 = get_hout(2);
        wa = e512;
        check_eq("sha512_word_a", w512[511:448], wa[511:448]);
        iv = rand_iv(64);
        for (int t = 0; t < 80; t++) wk_tab[t] = {$urandom, $urandom};
        run_block(2, iv, 40, 1'b1, -1, sha_model(64, 80, iv));
        @(negedge clk);

        // Abort at round 30, then a fresh "abc" block.
        build_abc(32, 64);
        run_block(1, iv256, 0, 1'b0, 30, e256);
        run_block(1, iv256, 0, 1'b0, -1, e256);
        @(negedge clk);
        check_eq("done_single_cycle", done_v[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
